// File: rtl/pipe_stage_buffer.sv
//------------------------------------------------------------------------------
// pipe_stage_buffer : elastic valid/ready stage register with two-entry skid,
//                     flush, hazard bubbles and saturating bubble counter.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_buffer #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 60,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hazard,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] c_st_empty = 2'd0;
  localparam logic [1:0] c_st_full  = 2'd1;
  localparam logic [1:0] c_st_skid  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_main_valid;
  logic              w_skid_valid;
  logic              w_accept;
  logic              w_fire;

  assign w_main_valid = (r_state != c_st_empty);
  assign w_skid_valid = (r_state == c_st_skid);
  assign w_accept     = in_valid && in_ready;
  assign w_fire       = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state <= c_st_empty;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_empty: if (w_accept) w_next_state = c_st_full;
      c_st_full: begin
        if (w_fire && !w_accept)      w_next_state = c_st_empty;
        else if (!w_fire && w_accept) w_next_state = c_st_skid;
      end
      c_st_skid:  if (w_fire) w_next_state = c_st_full;
      default:    w_next_state = c_st_empty;
    endcase
  end

  // Outputs: control is gated by the registered valid so bubbles carry no side effects
  always_comb begin
    in_ready  = !w_skid_valid && !hazard && !flush;
    out_valid = w_main_valid;
    out_ctrl  = w_main_valid ? r_main_ctrl : '0;
    out_data  = r_main_data;
  end

  // Main and skid payload storage; skid entry is always the younger one
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      case (r_state)
        c_st_empty: begin
          if (w_accept) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end
        end
        c_st_full: begin
          if (w_accept && w_fire) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end else if (w_accept) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
          end
        end
        c_st_skid: begin
          if (w_fire) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Bubble counter survives flush; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (hazard && in_valid && !w_skid_valid && !flush &&
                 (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule

`default_nettype wire
